// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: returns magnitude and full-circle atan2(y, x)
// of a signed Q1.14 vector using a start/busy/done handshake.
module cordic_vectoring #(
    parameter int WL     = 16,
    parameter int FL     = 14,
    parameter int N_ITER = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [WL-1:0] x_in,
    input  logic signed [WL-1:0] y_in,
    output logic signed [WL+1:0] mag_out,
    output logic signed [WL+1:0] angle_out,
    output logic                 busy,
    output logic                 done
);
    localparam int XW = WL + 3;
    localparam int ZW = WL + 2;
    localparam int PW = FL + ZW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ITER  = 2'd1;
    localparam logic [1:0] S_SCALE = 2'd2;

    localparam logic signed [ZW-1:0] PI_2 = ZW'(25736);
    localparam logic signed [PW-1:0] K    = PW'(9949);

    function automatic logic signed [ZW-1:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_lut = ZW'(12868);
            4'd1:    atan_lut = ZW'(7596);
            4'd2:    atan_lut = ZW'(4014);
            4'd3:    atan_lut = ZW'(2037);
            4'd4:    atan_lut = ZW'(1023);
            4'd5:    atan_lut = ZW'(512);
            4'd6:    atan_lut = ZW'(256);
            4'd7:    atan_lut = ZW'(128);
            4'd8:    atan_lut = ZW'(64);
            4'd9:    atan_lut = ZW'(32);
            4'd10:   atan_lut = ZW'(16);
            4'd11:   atan_lut = ZW'(8);
            4'd12:   atan_lut = ZW'(4);
            4'd13:   atan_lut = ZW'(2);
            4'd14:   atan_lut = ZW'(1);
            default: atan_lut = '0;
        endcase
    endfunction

    logic [1:0]           state_q, state_d;
    logic [3:0]           i_q, i_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d;
    logic signed [ZW-1:0] z_q, z_d;
    logic                 zero_q, zero_d;
    logic signed [ZW-1:0] mag_q, mag_d, ang_q, ang_d;
    logic                 busy_q, busy_d, done_q, done_d;

    // Widen before negating so that -(-32768) is representable.
    logic signed [XW-1:0] x_ext, y_ext, x_sh, y_sh;
    logic signed [PW-1:0] prod;

    assign x_ext = XW'(x_in);
    assign y_ext = XW'(y_in);
    assign x_sh  = x_q >>> i_q;
    assign y_sh  = y_q >>> i_q;
    assign prod  = PW'(x_q) * K;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        i_d     = i_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        zero_d  = zero_q;
        mag_d   = mag_q;
        ang_d   = ang_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ITER;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    i_d     = '0;
                    zero_d  = (x_in == '0) && (y_in == '0);
                    // Rotate left-half-plane vectors by -/+pi/2 so iterations converge.
                    if (!x_in[WL-1]) begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = '0;
                    end else if (!y_in[WL-1]) begin
                        x_d = y_ext;
                        y_d = -x_ext;
                        z_d = PI_2;
                    end else begin
                        x_d = -y_ext;
                        y_d = x_ext;
                        z_d = -PI_2;
                    end
                end
            end
            S_ITER: begin
                if (!y_q[XW-1]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_lut(i_q);
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_lut(i_q);
                end
                i_d = i_q + 4'd1;
                if (i_q == 4'(N_ITER - 1)) state_d = S_SCALE;
            end
            S_SCALE: begin
                // A zero vector has no defined angle; z would otherwise drift to sum(atan).
                mag_d   = zero_q ? '0 : ZW'(prod >>> FL);
                ang_d   = zero_q ? '0 : z_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments and an async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            mag_q   <= '0;
            ang_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            zero_q  <= zero_d;
            mag_q   <= mag_d;
            ang_q   <= ang_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mag_out   = mag_q;
    assign angle_out = ang_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_cordic_vectoring.sv
// Self-checking bench for cordic_vectoring: vector table with a scoreboard queue,
// plus busy-start, input-capture, done-hold and mid-operation reset sequences.
module tb_cordic_vectoring;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic signed [15:0] x_in = '0;
    logic signed [15:0] y_in = '0;
    logic signed [17:0] mag_out;
    logic signed [17:0] angle_out;
    logic               busy;
    logic               done;

    cordic_vectoring dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .mag_out   (mag_out),
        .angle_out (angle_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int  x;
        int  y;
        real mag;
        real ang;
        bit  model;
    } vec_t;

    typedef struct {
        string name;
        real   mag;
        real   ang;
        bit    exact;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    vec_t vecs[11];
    int   checks = 0;
    int   errors = 0;

    function automatic real rabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    task automatic check(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic compare_result(input exp_t e);
        real m;
        real a;
        m = real'(int'(mag_out));
        a = real'(int'(angle_out));
        last_exp = e;
        if (e.exact) begin
            check({e.name, "_mag"}, mag_out == 0, $sformatf("got %0d need 0", mag_out));
            check({e.name, "_ang"}, angle_out == 0, $sformatf("got %0d need 0", angle_out));
        end else begin
            check({e.name, "_mag"}, rabs(m - e.mag) <= 8.0 + 0.001 * e.mag,
                  $sformatf("got %0d need %0.1f", mag_out, e.mag));
            check({e.name, "_ang"}, rabs(a - e.ang) <= 8.0,
                  $sformatf("got %0d need %0.1f", angle_out, e.ang));
        end
    endtask

    // Drive one vector, check handshake timing, then pop and compare on done.
    task automatic run_one(input string name, input int x, input int y, input real mag,
                           input real ang, input bit exact, input bit noise);
        exp_t e;
        int   lat;
        int   busy_cnt;
        @(negedge clk);
        x_in  = 16'(x);
        y_in  = 16'(y);
        start = 1'b1;
        sb.push_back('{name, mag, ang, exact});
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, "_accept"}, busy === 1'b1 && done === 1'b0,
              $sformatf("busy=%0b done=%0b need busy=1 done=0", busy, done));
        x_in = ~x_in;
        y_in = 16'sd1234;
        lat = 0;
        busy_cnt = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy === 1'b1) busy_cnt++;
            if (noise) begin
                start = (lat >= 3 && lat <= 8);
                x_in  = 16'($urandom);
                y_in  = 16'($urandom);
            end
        end
        start = 1'b0;
        check({name, "_latency"}, lat == 16, $sformatf("got %0d edges need 16", lat));
        check({name, "_busy_cycles"}, busy_cnt == 16, $sformatf("got %0d need 16", busy_cnt));
        if (sb.size() == 0) begin
            check({name, "_scoreboard"}, 1'b0, "got empty queue need one entry");
        end else begin
            e = sb.pop_front();
            compare_result(e);
        end
    endtask

    initial begin
        vecs[0]  = '{16384, 0, 16384.0, 0.0, 1'b0};
        vecs[1]  = '{0, 16384, 16384.0, 25736.0, 1'b0};
        vecs[2]  = '{11585, 11585, 16384.0, 12868.0, 1'b0};
        vecs[3]  = '{-16384, 0, 16384.0, 51472.0, 1'b0};
        vecs[4]  = '{-16384, -16384, 23170.0, -38604.0, 1'b0};
        vecs[5]  = '{-32768, -32768, 46341.0, -38604.0, 1'b0};
        vecs[6]  = '{20000, -9000, 0.0, 0.0, 1'b1};
        vecs[7]  = '{-12000, 15000, 0.0, 0.0, 1'b1};
        vecs[8]  = '{-25000, -4000, 0.0, 0.0, 1'b1};
        vecs[9]  = '{3000, -30000, 0.0, 0.0, 1'b1};
        vecs[10] = '{32767, -32768, 0.0, 0.0, 1'b1};
        foreach (vecs[i]) begin
            if (vecs[i].model) begin
                vecs[i].mag = $sqrt(real'(vecs[i].x) * real'(vecs[i].x)
                                  + real'(vecs[i].y) * real'(vecs[i].y));
                vecs[i].ang = $atan2(real'(vecs[i].y), real'(vecs[i].x)) * 16384.0;
            end
        end

        #1;
        check("reset_state", mag_out == 0 && angle_out == 0 && busy == 0 && done == 0,
              $sformatf("got mag=%0d ang=%0d busy=%0b done=%0b need all 0",
                        mag_out, angle_out, busy, done));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_one($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].mag,
                    vecs[i].ang, 1'b0, 1'b0);
            if (vecs[i].x < 0 && vecs[i].y == 0)
                check("pi_positive", angle_out > 0, $sformatf("got %0d need > 0", angle_out));
        end

        run_one("zero", 0, 0, 0.0, 0.0, 1'b1, 1'b0);

        // Start pulses and input changes while busy must not disturb the result.
        run_one("busy_start", -16384, -16384, 23170.0, -38604.0, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("done_hold", done === 1'b1, $sformatf("got %0b need 1", done));
        compare_result('{"hold", last_exp.mag, last_exp.ang, last_exp.exact});

        // Reset during iteration 7 discards the computation.
        @(negedge clk);
        x_in  = 16'sd20000;
        y_in  = -16'sd9000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset", mag_out == 0 && angle_out == 0 && busy == 0 && done == 0,
              $sformatf("got mag=%0d ang=%0d busy=%0b done=%0b need all 0",
                        mag_out, angle_out, busy, done));
        @(negedge clk);
        rst_n = 1'b1;
        run_one("after_reset", 11585, 11585, 16384.0, 12868.0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
